deframing: RTL and testbench
============================

DEFRAMING -- requirements
Module: deframing

Interface
REQ-001 Parameter: D_BW, default 16, sample width on both the input and the output.
REQ-002 Parameter: FRAME_LEN, default 256, number of elements in one frame.
REQ-003 Parameter: CADENCE_CYC, default 3, number of cycles the transmitter holds each input element; legal values are 2 and above.
REQ-004 Port: clk_i, input, 1 bit, the only clock; all logic is on its rising edge.
REQ-005 Port: rst_i, input, 1 bit, synchronous active-high reset.
REQ-006 Port: en_i, input, 1 bit, block enable; low behaves exactly as rst_i high.
REQ-007 Port: data_i, input, D_BW bits signed, framed element held for CADENCE_CYC cycles.
REQ-008 Port: valid_i, input, 1 bit, high continuously for the whole duration of a frame.
REQ-009 Port: last_i, input, 1 bit, high for one cycle on the final cadence cycle of element FRAME_LEN-1.
REQ-010 Port: data_o, output, D_BW bits signed, drained element.
REQ-011 Port: valid_o, output, 1 bit, data_o is valid.
REQ-012 Port: ready_i, input, 1 bit, downstream accepts data_o.
REQ-013 Port: last_o, output, 1 bit, data_o is element FRAME_LEN-1.
REQ-014 Port: err_len_o, output, 1 bit, one-cycle pulse when a frame is malformed.
REQ-015 Port: drop_o, output, 1 bit, one-cycle pulse when a frame is discarded because the buffer is busy.

Function
REQ-016 Storage: one FRAME_LEN x D_BW buffer; capture index and drain index each $clog2(FRAME_LEN) bits; cadence counter $clog2(CADENCE_CYC) bits.
REQ-017 States: IDLE, CAPTURE, DRAIN, DISCARD.
REQ-018 Cadence counter: cleared whenever valid_i is low, otherwise incremented, wrapping to 0 after CADENCE_CYC-1. A capture strobe occurs on each cycle where valid_i is high and the counter equals CADENCE_CYC-1.
REQ-019 IDLE: on valid_i high, move to CAPTURE with the capture index at 0; the first cycle of valid_i counts as cadence cycle 0.
REQ-020 CAPTURE: on each capture strobe, write data_i to buffer[capture index] and increment the capture index.
REQ-021 CAPTURE, good end: a strobe with last_i high and capture index == FRAME_LEN-1 writes the element and moves to DRAIN, with the drain index at 0.
REQ-022 CAPTURE, length error: err_len_o pulses in the cycle after the error is detected, and the state moves to DISCARD, in any of these cases: last_i high with capture index != FRAME_LEN-1; last_i high on a cycle that is not a strobe; valid_i falling before a good end.
REQ-023 DISCARD: wait for valid_i low, then move to IDLE; no data is emitted.
REQ-024 DRAIN: valid_o is high in every DRAIN cycle; data_o = buffer[drain index]; last_o = valid_o when drain index == FRAME_LEN-1.
REQ-025 DRAIN handshake: a transfer occurs when valid_o and ready_i are both high; a transfer increments the drain index. data_o and last_o hold stable while ready_i is low.
REQ-026 DRAIN exit: the transfer with last_o high returns the state to IDLE; valid_o is low in the next cycle.
REQ-027 DRAIN busy: a valid_i rising edge during DRAIN causes drop_o to pulse once and that frame is ignored until valid_i falls; the drain continues unaffected.
REQ-028 DRAIN timing: if DRAIN exits while an ignored frame is still active, that frame is still ignored; IDLE only accepts a new valid_i rising edge.
REQ-029 Latency: valid_o first rises in the cycle after the last_i capture edge. With ready_i held high, the FRAME_LEN elements drain on consecutive cycles.
REQ-030 Back-to-back framing: valid_i may fall and rise again one cycle later; IDLE accepts that frame.

Reset
REQ-031 On rst_i or !en_i: state = IDLE, all indices and the cadence counter = 0, and valid_o, last_o, err_len_o, drop_o = 0. Buffer contents are not reset.
REQ-032 A reset in the middle of a capture or drain abandons the frame; no output is asserted until a new complete frame has been captured.

Verification
REQ-033 Scenario, nominal frame: CADENCE_CYC=3, FRAME_LEN=256, data_i = element index, ready_i = 1 -> 256 outputs 0..255 on consecutive cycles, last_o only on 255, valid_o rising one cycle after last_i.
REQ-034 Scenario, backpressure: ready_i toggled 1,0,0,1 repeatedly -> data_o stable while stalled, output sequence exact and complete, last_o on 255 only.
REQ-035 Scenario, short frame: last_i on element 99 -> err_len_o single pulse, no valid_o, and the next good frame is emitted correctly.
REQ-036 Scenario, valid drop: valid_i falls after element 10 -> err_len_o pulse, return to IDLE, no output.
REQ-037 Scenario, busy drop: a second frame starts while the first is draining with ready_i = 0 -> drop_o single pulse, first frame emitted intact, second frame never emitted.
REQ-038 Scenario, reset mid-drain: rst_i high for 1 cycle at drain index 50 -> valid_o low the next cycle, and the following frame drains from element 0.

Source files
------------

// File: rtl/deframing_if.sv
// Stream bundle for the deframer: a cadence-held framed input stream and a
// valid/ready output stream, plus the two status pulses.
interface deframing_if #(
    parameter int D_BW = 16
);
    logic signed [D_BW-1:0] data_i;
    logic                   valid_i;
    logic                   last_i;
    logic signed [D_BW-1:0] data_o;
    logic                   valid_o;
    logic                   ready_i;
    logic                   last_o;
    logic                   err_len_o;
    logic                   drop_o;

    // Traffic source / sink side (testbench or surrounding logic)
    modport master (
        output data_i, valid_i, last_i, ready_i,
        input  data_o, valid_o, last_o, err_len_o, drop_o
    );

    // Deframer side
    modport slave (
        input  data_i, valid_i, last_i, ready_i,
        output data_o, valid_o, last_o, err_len_o, drop_o
    );
endinterface

// File: rtl/deframing.sv
// Deframer: samples each input element once per cadence period into a frame
// buffer, checks the frame length against last_i, then drains the complete
// frame through a valid/ready handshake. Frames arriving while a drain is in
// progress are dropped whole. FRAME_LEN must be at least 2.
module deframing #(
    parameter int D_BW        = 16,
    parameter int FRAME_LEN   = 256,
    parameter int CADENCE_CYC = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    deframing_if.slave  bus
);
    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam int CNT_W = $clog2(CADENCE_CYC);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CAD_LAST = CNT_W'(CADENCE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cad_cnt;
    logic [IDX_W-1:0]       cap_idx;
    logic [IDX_W-1:0]       drn_idx;
    logic                   valid_d;
    logic signed [D_BW-1:0] mem [FRAME_LEN];

    logic             run;
    logic             strobe;
    logic             rise;
    logic             cap_wr;
    logic             good_end;
    logic             bad_end;
    logic             xfer;
    logic             drn_end;
    logic [IDX_W-1:0] cap_nxt;
    logic [IDX_W-1:0] drn_nxt;

    // Decode strobes, frame-end conditions and handshake events for this cycle
    always_comb begin
        run      = en_i && !rst_i;
        strobe   = bus.valid_i && (cad_cnt == CAD_LAST);
        rise     = bus.valid_i && !valid_d;
        cap_wr   = (state == CAPTURE) && strobe;
        good_end = cap_wr && bus.last_i && (cap_idx == LAST_IDX);
        // last_i off-strobe, last_i at the wrong index, or valid_i dropping early
        bad_end  = (state == CAPTURE) && (!bus.valid_i || (bus.last_i && !good_end));
        xfer     = (state == DRAIN) && bus.valid_o && bus.ready_i;
        drn_end  = xfer && (drn_idx == LAST_IDX);
        cap_nxt  = (cap_idx == LAST_IDX) ? '0 : cap_idx + IDX_W'(1);
        drn_nxt  = (drn_idx == LAST_IDX) ? '0 : drn_idx + IDX_W'(1);
    end

    // Frame state machine, cadence counter and registered control outputs
    always_ff @(posedge clk_i) begin
        if (!run) begin
            state         <= IDLE;
            cad_cnt       <= '0;
            cap_idx       <= '0;
            drn_idx       <= '0;
            valid_d       <= 1'b0;
            bus.valid_o   <= 1'b0;
            bus.last_o    <= 1'b0;
            bus.err_len_o <= 1'b0;
            bus.drop_o    <= 1'b0;
        end else begin
            valid_d       <= bus.valid_i;
            bus.err_len_o <= 1'b0;
            bus.drop_o    <= 1'b0;
            if (!bus.valid_i || cad_cnt == CAD_LAST) begin
                cad_cnt <= '0;
            end else begin
                cad_cnt <= cad_cnt + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    // Only a fresh rising edge starts a frame; a frame that was
                    // already running when we got here stays ignored.
                    if (rise) begin
                        state   <= CAPTURE;
                        cap_idx <= '0;
                    end
                end
                CAPTURE: begin
                    if (bad_end) begin
                        state         <= DISCARD;
                        bus.err_len_o <= 1'b1;
                    end else if (good_end) begin
                        state       <= DRAIN;
                        drn_idx     <= '0;
                        bus.valid_o <= 1'b1;
                        bus.last_o  <= 1'b0;
                    end else if (cap_wr) begin
                        cap_idx <= cap_nxt;
                    end
                end
                DRAIN: begin
                    if (rise) begin
                        bus.drop_o <= 1'b1;
                    end
                    if (drn_end) begin
                        state       <= IDLE;
                        bus.valid_o <= 1'b0;
                        bus.last_o  <= 1'b0;
                    end else if (xfer) begin
                        drn_idx    <= drn_nxt;
                        bus.last_o <= (drn_nxt == LAST_IDX);
                    end
                end
                DISCARD: begin
                    if (!bus.valid_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Frame buffer write and look-ahead read into the output data register
    always_ff @(posedge clk_i) begin
        if (run && cap_wr) begin
            mem[cap_idx] <= bus.data_i;
        end
        if (run && good_end) begin
            bus.data_o <= mem[0];
        end else if (run && xfer && !drn_end) begin
            bus.data_o <= mem[drn_nxt];
        end
    end
endmodule

// File: tb/tb_deframing.sv
// Scoreboard bench for the deframer: the stimulus thread queues the expected
// output of every frame it sends; a negedge monitor pops and compares on each
// handshake and also watches stall stability, latency and status pulses.
module tb_deframing;
    localparam int D_BW      = 16;
    localparam int FRAME_LEN = 256;
    localparam int CAD       = 3;

    typedef struct packed {
        logic signed [D_BW-1:0] data;
        logic                   last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic en;

    always #5 clk = ~clk;

    deframing_if #(.D_BW(D_BW)) bus ();

    deframing #(
        .D_BW(D_BW),
        .FRAME_LEN(FRAME_LEN),
        .CADENCE_CYC(CAD)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .en_i(en),
        .bus(bus)
    );

    exp_t q[$];
    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int rdy_mode  = 0;
    int last_seen = -100;
    int rise_cyc  = 0;
    int lastx_cyc = 0;
    int err_hi    = 0;
    int drop_hi   = 0;
    int err_lat   = 0;
    bit mon_on    = 1'b0;
    logic pv_stall = 1'b0;
    logic pv_vo    = 1'b0;
    logic pv_last  = 1'b0;
    logic signed [D_BW-1:0] pv_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, req);
        end
    endtask

    // ready_i: 0 = always ready, 1 = pattern 1,0,0,1, other = stalled
    initial begin
        bus.ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.ready_i = 1'b1;
                1:       bus.ready_i = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: bus.ready_i = 1'b0;
            endcase
        end
    end

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (bus.valid_i && bus.last_i) last_seen = cyc;
                if (bus.err_len_o) begin
                    err_hi++;
                    err_lat = cyc - last_seen;
                end
                if (bus.drop_o) drop_hi++;
                if (pv_stall) begin
                    check("stall_valid", bus.valid_o, 1);
                    check("stall_data", bus.data_o, pv_data);
                    check("stall_last", bus.last_o, pv_last);
                end
                if (bus.valid_o && !pv_vo) begin
                    rise_cyc = cyc;
                    check("latency", cyc, last_seen + 1);
                end
                if (bus.valid_o && bus.ready_i) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output actual data %0d required no output", bus.data_o);
                    end else begin
                        e = q.pop_front();
                        check("data", bus.data_o, e.data);
                        check("last", bus.last_o, e.last);
                        if (bus.last_o) lastx_cyc = cyc;
                    end
                end
                pv_stall = bus.valid_o && !bus.ready_i;
                pv_data  = bus.data_o;
                pv_last  = bus.last_o;
                pv_vo    = bus.valid_o;
            end
        end
    end

    // Drives n elements starting at value base; last_i on element last_idx
    // (-1: none); ends with one idle cycle. exp_out queues the full frame.
    task automatic drive_frame(input int n, input int last_idx, input int base,
                               input bit exp_out);
        if (exp_out) begin
            for (int e = 0; e < FRAME_LEN; e++) begin
                exp_t x;
                x.data = D_BW'(base + e);
                x.last = (e == FRAME_LEN - 1);
                q.push_back(x);
            end
        end
        for (int e = 0; e < n; e++) begin
            for (int c = 0; c < CAD; c++) begin
                @(posedge clk);
                #1;
                bus.valid_i = 1'b1;
                bus.data_i  = D_BW'(base + e);
                bus.last_i  = (e == last_idx) && (c == CAD - 1);
            end
        end
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        bus.last_i  = 1'b0;
        bus.data_i  = '0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((q.size() != 0 || bus.valid_o) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, (q.size() == 0 && !bus.valid_o), 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int e0;
        int d0;
        int n;
        bit found;
        bus.valid_i = 1'b0;
        bus.last_i  = 1'b0;
        bus.data_i  = '0;
        rst = 1'b1;
        en  = 1'b1;
        idle(3);
        check("reset_valid_o", bus.valid_o, 0);
        check("reset_last_o", bus.last_o, 0);
        check("reset_err_len_o", bus.err_len_o, 0);
        check("reset_drop_o", bus.drop_o, 0);
        rst    = 1'b0;
        mon_on = 1'b1;

        // Disabled block ignores a complete frame
        en = 1'b0;
        drive_frame(FRAME_LEN, FRAME_LEN - 1, 5000, 1'b0);
        idle(3);
        check("en_low_valid_o", bus.valid_o, 0);
        check("en_low_err", err_hi, 0);
        en = 1'b1;
        idle(2);

        // Nominal frame, data = element index
        rdy_mode = 0;
        drive_frame(FRAME_LEN, FRAME_LEN - 1, 0, 1'b1);
        wait_drain("nominal", 2000);
        check("nominal_span", lastx_cyc - rise_cyc, FRAME_LEN - 1);
        idle(2);

        // Backpressure 1,0,0,1
        rdy_mode = 1;
        drive_frame(FRAME_LEN, FRAME_LEN - 1, 1000, 1'b1);
        wait_drain("backpressure", 3000);
        rdy_mode = 0;
        idle(2);

        // Short frame, then a good frame one idle cycle later
        e0 = err_hi;
        drive_frame(100, 99, 2000, 1'b0);
        drive_frame(FRAME_LEN, FRAME_LEN - 1, -500, 1'b1);
        wait_drain("after_short", 2000);
        check("short_err_pulses", err_hi - e0, 1);
        check("short_err_latency", err_lat, 1);
        idle(2);

        // valid_i falls after element 10
        e0 = err_hi;
        drive_frame(11, -1, 3000, 1'b0);
        idle(6);
        check("vdrop_err_pulses", err_hi - e0, 1);
        check("vdrop_valid_o", bus.valid_o, 0);

        // Second frame arrives while the first is stalled in drain; the drain
        // then finishes while the dropped frame is still active
        d0 = drop_hi;
        rdy_mode = 2;
        drive_frame(FRAME_LEN, FRAME_LEN - 1, 4000, 1'b1);
        idle(3);
        fork
            drive_frame(FRAME_LEN, FRAME_LEN - 1, 6000, 1'b0);
            begin
                repeat (40) @(posedge clk);
                #1 rdy_mode = 0;
            end
        join
        wait_drain("busy", 2000);
        check("busy_drop_pulses", drop_hi - d0, 1);
        idle(4);

        // Reset for one cycle at drain index 50
        drive_frame(FRAME_LEN, FRAME_LEN - 1, 7000, 1'b1);
        n = 0;
        found = 1'b0;
        while (!found && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.valid_o && bus.data_o == D_BW'(7050)) found = 1'b1;
        end
        check("rst_point_found", found, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_valid_o", bus.valid_o, 0);
        check("rst_last_o", bus.last_o, 0);
        check("rst_remaining", q.size(), FRAME_LEN - 51);
        q.delete();
        idle(2);
        drive_frame(FRAME_LEN, FRAME_LEN - 1, -9000, 1'b1);
        wait_drain("after_reset", 2000);

        idle(4);
        check("total_err_pulses", err_hi, 2);
        check("total_drop_pulses", drop_hi, 1);
        check("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual timeout required completion");
        $fatal(1, "watchdog");
    end
endmodule
